// File: rtl/rotator_cmd_queue_pkg.sv
// Shared definitions for the rotator command queue and the rotator bench.
package rotator_cmd_queue_pkg;

  // Barrel rotator opcodes
  localparam logic [1:0] ROT_HOLD  = 2'b00;
  localparam logic [1:0] ROT_LEFT  = 2'b01;
  localparam logic [1:0] ROT_RIGHT = 2'b10;
  localparam logic [1:0] ROT_LOAD  = 2'b11;

  // Command entry width: op(2) + amt(3) + data(8) + rep(2)
  localparam int unsigned CMD_W = 15;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] data;
    logic [1:0] rep;
  } cmd_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/rotator_cmd_queue_cmd_fifo.sv
// Command FIFO: power-of-two depth, wrapping pointers, registered level.
module cmd_fifo
  import rotator_cmd_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [CMD_W-1:0]         wdata,
  input  logic                     pop,
  output logic [CMD_W-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally modulo DEPTH; level tracks push/pop balance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rotator_cmd_queue.sv
// Queues rotator commands and issues each one for rep+1 cycles onto the
// barrel rotator control inputs.
module rotator_cmd_queue
  import rotator_cmd_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [2:0]             in_amt,
  input  logic [7:0]             in_data,
  input  logic [1:0]             in_rep,
  output logic [1:0]             rot_c,
  output logic [2:0]             rot_s,
  output logic [7:0]             rot_i,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  state_t     state_q, state_d;
  logic [1:0] rep_q, rep_d;
  logic [1:0] rot_c_d;
  logic [2:0] rot_s_d;
  logic [7:0] rot_i_d;

  logic       push, pop, full, empty;
  cmd_t       in_cmd, head;
  logic [CMD_W-1:0] head_raw;

  assign in_cmd   = '{op: in_op, amt: in_amt, data: in_data, rep: in_rep};
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = cmd_t'(head_raw);
  assign busy     = (state_q == S_ISSUE);

  cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_cmd),
    .pop   (pop),
    .rdata (head_raw),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Next-state and issue-register logic; pops only from registered level
  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    rot_c_d = rot_c;
    rot_s_d = rot_s;
    rot_i_d = rot_i;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          rot_c_d = head.op;
          rot_s_d = head.amt;
          rot_i_d = head.data;
          rep_d   = head.rep;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rep_q != '0) begin
          rep_d = rep_q - 2'd1;
        end else if (!empty) begin
          pop     = 1'b1;
          rot_c_d = head.op;
          rot_s_d = head.amt;
          rot_i_d = head.data;
          rep_d   = head.rep;
        end else begin
          rot_c_d = ROT_HOLD;
          rot_s_d = '0;
          rot_i_d = '0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and issue registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rep_q   <= '0;
      rot_c   <= ROT_HOLD;
      rot_s   <= '0;
      rot_i   <= '0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      rot_c   <= rot_c_d;
      rot_s   <= rot_s_d;
      rot_i   <= rot_i_d;
    end
  end

endmodule

// File: tb/tb_rotator_cmd_queue.sv
// Directed bench for rotator_cmd_queue with a small barrel rotator model.
module tb_rotator_cmd_queue;
  import rotator_cmd_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [2:0] in_amt;
  logic [7:0] in_data;
  logic [1:0] in_rep;
  logic [1:0] rot_c;
  logic [2:0] rot_s;
  logic [7:0] rot_i;
  logic       busy;
  logic [2:0] level;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rq = 8'h00;

  always #5 clk = ~clk;

  rotator_cmd_queue #(
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_amt   (in_amt),
    .in_data  (in_data),
    .in_rep   (in_rep),
    .rot_c    (rot_c),
    .rot_s    (rot_s),
    .rot_i    (rot_i),
    .busy     (busy),
    .level    (level)
  );

  // Barrel rotator driven by the queue outputs
  always @(posedge clk) begin
    case (rot_c)
      ROT_LEFT:  rq <= (rq << rot_s) | (rq >> (4'd8 - {1'b0, rot_s}));
      ROT_RIGHT: rq <= (rq >> rot_s) | (rq << (4'd8 - {1'b0, rot_s}));
      ROT_LOAD:  rq <= rot_i;
      default:   rq <= rq;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [1:0] op, input logic [2:0] amt,
                       input logic [7:0] d, input logic [1:0] r);
    in_valid = 1'b1;
    in_op    = op;
    in_amt   = amt;
    in_data  = d;
    in_rep   = r;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_op    = 2'd0;
    in_amt   = 3'd0;
    in_data  = 8'd0;
    in_rep   = 2'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rot_c", 32'(rot_c), 32'd0);
    chk("rst_rot_s", 32'(rot_s), 32'd0);
    chk("rst_rot_i", 32'(rot_i), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Single load, rep 0: one cycle of issue after one cycle of latency
    offer(2'd3, 3'd0, 8'hA5, 2'd0);
    step();
    idle_in();
    chk("ld_push_level", 32'(level), 32'd1);
    chk("ld_push_rot_c", 32'(rot_c), 32'd0);
    chk("ld_push_busy", 32'(busy), 32'd0);
    step();
    chk("ld_issue_rot_c", 32'(rot_c), 32'd3);
    chk("ld_issue_rot_i", 32'(rot_i), 32'hA5);
    chk("ld_issue_busy", 32'(busy), 32'd1);
    chk("ld_issue_level", 32'(level), 32'd0);
    step();
    chk("ld_done_rot_c", 32'(rot_c), 32'd0);
    chk("ld_done_rot_i", 32'(rot_i), 32'd0);
    chk("ld_done_busy", 32'(busy), 32'd0);

    // Preload 81, then rotate left by 3 three times
    offer(2'd3, 3'd0, 8'h81, 2'd0);
    step();
    offer(2'd1, 3'd3, 8'h00, 2'd2);
    step();
    idle_in();
    chk("rl_load_rot_c", 32'(rot_c), 32'd3);
    chk("rl_load_rot_i", 32'(rot_i), 32'h81);
    step();
    chk("rl_c1_rot_c", 32'(rot_c), 32'd1);
    chk("rl_c1_rot_s", 32'(rot_s), 32'd3);
    chk("rl_c1_rq", 32'(rq), 32'h81);
    step();
    chk("rl_c2_rot_c", 32'(rot_c), 32'd1);
    chk("rl_c2_rq", 32'(rq), 32'h0C);
    step();
    chk("rl_c3_rot_c", 32'(rot_c), 32'd1);
    chk("rl_c3_rot_s", 32'(rot_s), 32'd3);
    chk("rl_c3_rq", 32'(rq), 32'h60);
    step();
    chk("rl_end_rot_c", 32'(rot_c), 32'd0);
    chk("rl_end_busy", 32'(busy), 32'd0);
    chk("rl_end_rq", 32'(rq), 32'h03);

    // Fill to DEPTH while a rep=3 command issues; 5th push must be dropped
    offer(2'd2, 3'd7, 8'hEE, 2'd3);
    step();
    chk("fl_x_level", 32'(level), 32'd1);
    offer(2'd2, 3'd1, 8'h11, 2'd0);
    step();
    chk("fl_x_rot_c", 32'(rot_c), 32'd2);
    chk("fl_x_rot_s", 32'(rot_s), 32'd7);
    chk("fl_lvl1", 32'(level), 32'd1);
    offer(2'd0, 3'd0, 8'h22, 2'd0);
    step();
    chk("fl_lvl2", 32'(level), 32'd2);
    offer(2'd1, 3'd0, 8'h33, 2'd0);
    step();
    chk("fl_lvl3", 32'(level), 32'd3);
    offer(2'd3, 3'd5, 8'h44, 2'd0);
    step();
    chk("fl_lvl4", 32'(level), 32'd4);
    chk("fl_full_ready", 32'(in_ready), 32'd0);
    chk("fl_x_still", 32'(rot_i), 32'hEE);
    offer(2'd3, 3'd7, 8'hFF, 2'd0);
    step();
    idle_in();
    chk("fl_c0_level", 32'(level), 32'd3);
    chk("fl_c0_ready", 32'(in_ready), 32'd1);
    chk("fl_c0_rot_c", 32'(rot_c), 32'd2);
    chk("fl_c0_rot_s", 32'(rot_s), 32'd1);
    chk("fl_c0_rot_i", 32'(rot_i), 32'h11);
    step();
    chk("fl_c1_rot_c", 32'(rot_c), 32'd0);
    chk("fl_c1_rot_i", 32'(rot_i), 32'h22);
    chk("fl_c1_busy", 32'(busy), 32'd1);
    step();
    chk("fl_c2_rot_c", 32'(rot_c), 32'd1);
    chk("fl_c2_rot_s", 32'(rot_s), 32'd0);
    chk("fl_c2_rot_i", 32'(rot_i), 32'h33);
    step();
    chk("fl_c3_rot_c", 32'(rot_c), 32'd3);
    chk("fl_c3_rot_s", 32'(rot_s), 32'd5);
    chk("fl_c3_rot_i", 32'(rot_i), 32'h44);
    chk("fl_c3_level", 32'(level), 32'd0);
    step();
    chk("fl_end_rot_c", 32'(rot_c), 32'd0);
    chk("fl_end_rot_i", 32'(rot_i), 32'd0);
    chk("fl_end_busy", 32'(busy), 32'd0);

    // Streaming push+pop every cycle; pointers wrap several times
    offer(2'd3, 3'd0, 8'h10, 2'd0);
    step();
    chk("st_start_level", 32'(level), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      offer(2'd3, 3'(i), 8'h10 + 8'(i), 2'd0);
      step();
      chk("st_level", 32'(level), 32'd1);
      chk("st_rot_i", 32'(rot_i), 32'h10 + 32'(i - 1));
      chk("st_rot_s", 32'(rot_s), 32'((i - 1) % 8));
    end
    idle_in();
    step();
    chk("st_last_rot_i", 32'(rot_i), 32'h1A);
    chk("st_last_level", 32'(level), 32'd0);
    step();
    chk("st_end_rot_c", 32'(rot_c), 32'd0);
    chk("st_end_busy", 32'(busy), 32'd0);

    // Reset mid-burst with three commands queued
    offer(2'd1, 3'd2, 8'h00, 2'd3);
    step();
    offer(2'd3, 3'd0, 8'hAA, 2'd0);
    step();
    chk("mr_rot_c", 32'(rot_c), 32'd1);
    offer(2'd3, 3'd0, 8'hBB, 2'd0);
    step();
    offer(2'd3, 3'd0, 8'hCC, 2'd0);
    step();
    idle_in();
    chk("mr_pre_level", 32'(level), 32'd3);
    chk("mr_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async_rot_c", 32'(rot_c), 32'd0);
    chk("mr_async_rot_s", 32'(rot_s), 32'd0);
    chk("mr_async_rot_i", 32'(rot_i), 32'd0);
    chk("mr_async_level", 32'(level), 32'd0);
    chk("mr_async_busy", 32'(busy), 32'd0);
    chk("mr_async_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    offer(2'd3, 3'd0, 8'h5A, 2'd0);
    step();
    idle_in();
    chk("mr_push_level", 32'(level), 32'd1);
    chk("mr_push_rot_c", 32'(rot_c), 32'd0);
    step();
    chk("mr_issue_rot_c", 32'(rot_c), 32'd3);
    chk("mr_issue_rot_i", 32'(rot_i), 32'h5A);
    step();
    chk("mr_end_rot_c", 32'(rot_c), 32'd0);
    chk("mr_end_level", 32'(level), 32'd0);
    chk("mr_end_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
